// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the CPU boot path
package cpu_pkg;

    localparam int LOADER_MAX_WORDS = 256;

    typedef enum logic [2:0] {
        eCntLo = 3'd0,
        eCntHi = 3'd1,
        eDatLo = 3'd2,
        eDatHi = 3'd3,
        eSumLo = 3'd4,
        eSumHi = 3'd5,
        eRun   = 3'd6,
        eError = 3'd7
    } loader_state_e;

    // States in which the incoming byte completes a little-endian field
    function automatic logic is_hi_byte(input loader_state_e s);
        return (s == eCntHi) || (s == eDatHi) || (s == eSumHi);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in, instruction memory write port out
interface prog_loader_if #(
    parameter int ADDR_W = 9
);
    logic [7:0]        rx_data_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic              imem_wen_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [15:0]       imem_data_o;

    modport master (
        input  rx_data_i, rx_valid_i,
        output rx_ready_o, imem_wen_o, imem_addr_o, imem_data_o
    );

    modport slave (
        output rx_data_i, rx_valid_i,
        input  rx_ready_o, imem_wen_o, imem_addr_o, imem_data_o
    );
endinterface

// File: rtl/byte_pair_asm.sv
// rtl/byte_pair_asm.sv - pairs low/high bytes into a 16-bit little-endian word
module byte_pair_asm (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        i_valid,
    input  logic        i_is_hi,
    input  logic [7:0]  i_data,
    output logic [15:0] o_word,
    output logic        o_word_valid
);
    logic [7:0] r_lo;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_lo <= 8'h00;
        end else if (i_valid && !i_is_hi) begin
            r_lo <= i_data;
        end
    end

    // Word is presented in the same cycle the high byte is accepted
    assign o_word       = {i_data, r_lo};
    assign o_word_valid = i_valid && i_is_hi;
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - frames a program image into instruction memory and releases the CPU
module prog_loader
    import cpu_pkg::*;
#(
    parameter int MAX_WORDS = LOADER_MAX_WORDS,
    parameter int ADDR_W    = 9
) (
    input  logic          clk_i,
    input  logic          reset,
    prog_loader_if.master bus,
    output logic          cpu_reset_o,
    output logic          done_o,
    output logic          error_o
);
    // Index must reach MAX_WORDS itself without wrapping
    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    loader_state_e     r_state;
    logic [15:0]       r_count;
    logic [15:0]       r_xor;
    logic [IDX_W-1:0]  r_index;
    logic              r_rx_ready;
    logic              r_imem_wen;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [15:0]       r_imem_data;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic              w_is_hi;
    logic [15:0]       w_word;
    logic              w_word_valid;
    logic [IDX_W-1:0]  w_index_nxt;

    assign w_accept    = bus.rx_valid_i && r_rx_ready;
    assign w_is_hi     = is_hi_byte(r_state);
    assign w_index_nxt = r_index + 1'b1;

    byte_pair_asm u_asm (
        .clk_i        (clk_i),
        .reset        (reset),
        .i_valid      (w_accept),
        .i_is_hi      (w_is_hi),
        .i_data       (bus.rx_data_i),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state     <= eCntLo;
            r_count     <= 16'h0000;
            r_xor       <= 16'h0000;
            r_index     <= '0;
            r_rx_ready  <= 1'b1;
            r_imem_wen  <= 1'b0;
            r_imem_addr <= '0;
            r_imem_data <= 16'h0000;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_imem_wen <= 1'b0;
            case (r_state)
                eCntLo: if (w_accept) r_state <= eCntHi;
                eCntHi: if (w_word_valid) begin
                    r_count <= w_word;
                    r_index <= '0;
                    r_xor   <= 16'h0000;
                    if (w_word > 16'(MAX_WORDS)) begin
                        r_state    <= eError;
                        r_rx_ready <= 1'b0;
                        r_error    <= 1'b1;
                    end else if (w_word == 16'h0000) begin
                        r_state <= eSumLo;
                    end else begin
                        r_state <= eDatLo;
                    end
                end
                eDatLo: if (w_accept) r_state <= eDatHi;
                eDatHi: if (w_word_valid) begin
                    r_imem_wen  <= 1'b1;
                    r_imem_addr <= {r_index[ADDR_W-2:0], 1'b0};
                    r_imem_data <= w_word;
                    r_xor       <= r_xor ^ w_word;
                    r_index     <= w_index_nxt;
                    r_state     <= (16'(w_index_nxt) == r_count) ? eSumLo : eDatLo;
                end
                eSumLo: if (w_accept) r_state <= eSumHi;
                eSumHi: if (w_word_valid) begin
                    r_rx_ready <= 1'b0;
                    if (w_word == r_xor) begin
                        r_state     <= eRun;
                        r_cpu_reset <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_state <= eError;
                        r_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready_o  = r_rx_ready;
    assign bus.imem_wen_o  = r_imem_wen;
    assign bus.imem_addr_o = r_imem_addr;
    assign bus.imem_data_o = r_imem_data;
    assign cpu_reset_o     = r_cpu_reset;
    assign done_o          = r_done;
    assign error_o         = r_error;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with a frame-level model
module tb_prog_loader;

    logic       clk_i = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cpu_reset_o;
    logic       done_o;
    logic       error_o;

    always #5 clk_i = ~clk_i;

    prog_loader_if #(.ADDR_W(9)) bus ();
    assign bus.rx_valid_i = rx_valid;
    assign bus.rx_data_i  = rx_data;

    prog_loader #(.MAX_WORDS(256), .ADDR_W(9)) dut (
        .clk_i       (clk_i),
        .reset       (rst),
        .bus         (bus),
        .cpu_reset_o (cpu_reset_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model: phase 0 receiving, 1 running, 2 error
    logic [7:0]  m_bytes[$];
    int          m_phase;
    int          m_cnt;
    logic        m_wen;
    logic [8:0]  m_addr;
    logic [15:0] m_data;
    bit          m_valid = 1'b0;

    logic [24:0] obs_log[$];
    logic [15:0] tb_mem[256];
    logic [7:0]  tx_q[$];
    logic [15:0] img[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] log_at(input int i);
        if (i < 0 || i >= obs_log.size()) return 25'h1FFFFFF;
        return obs_log[i];
    endfunction

    task automatic model_step();
        int n;
        logic [15:0] sum;
        logic [15:0] x;
        if (rst) begin
            m_bytes.delete();
            m_phase = 0;
            m_cnt   = 0;
            m_wen   = 1'b0;
            m_addr  = 9'h000;
            m_data  = 16'h0000;
            m_valid = 1'b1;
            return;
        end
        m_wen = 1'b0;
        if (rx_valid && m_phase == 0) begin
            m_bytes.push_back(rx_data);
            n = m_bytes.size();
            if (n == 2) begin
                m_cnt = int'({m_bytes[1], m_bytes[0]});
                if (m_cnt > 256) m_phase = 2;
            end else if (n == 4 + 2 * m_cnt) begin
                sum = {m_bytes[n-1], m_bytes[n-2]};
                x = 16'h0000;
                for (int k = 0; k < m_cnt; k++) x ^= {m_bytes[3+2*k], m_bytes[2+2*k]};
                m_phase = (sum == x) ? 1 : 2;
            end else if (n > 2 && n % 2 == 0) begin
                m_wen  = 1'b1;
                m_addr = 9'(n - 4);
                m_data = {m_bytes[n-1], m_bytes[n-2]};
            end
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        model_step();
    end

    initial forever begin
        @(negedge clk_i);
        if (m_valid) begin
            check("rx_ready_o", 32'(bus.rx_ready_o), 32'(m_phase == 0));
            check("imem_wen_o", 32'(bus.imem_wen_o), 32'(m_wen));
            check("cpu_reset_o", 32'(cpu_reset_o), 32'(m_phase != 1));
            check("done_o", 32'(done_o), 32'(m_phase == 1));
            check("error_o", 32'(error_o), 32'(m_phase == 2));
            if (m_wen) begin
                check("imem_addr_o", 32'(bus.imem_addr_o), 32'(m_addr));
                check("imem_data_o", 32'(bus.imem_data_o), 32'(m_data));
            end
        end
        if (bus.imem_wen_o === 1'b1) begin
            obs_log.push_back({bus.imem_addr_o, bus.imem_data_o});
            tb_mem[bus.imem_addr_o[8:1]] = bus.imem_data_o;
        end
    end

    task automatic drive_byte(input logic [7:0] b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk_i);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk_i);
        rx_valid = 1'b0;
    endtask

    task automatic send_q(input int gap_max);
        foreach (tx_q[i]) drive_byte(tx_q[i], gap_max);
        tx_q.delete();
    endtask

    task automatic push_word(input logic [15:0] w);
        tx_q.push_back(w[7:0]);
        tx_q.push_back(w[15:8]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk_i);
        rst = 1'b0;
        obs_log.delete();
    endtask

    initial begin
        logic [15:0] x;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk_i);
        check("reset rx_ready_o", 32'(bus.rx_ready_o), 32'd1);
        check("reset imem_wen_o", 32'(bus.imem_wen_o), 32'd0);
        check("reset imem_addr_o", 32'(bus.imem_addr_o), 32'd0);
        check("reset imem_data_o", 32'(bus.imem_data_o), 32'd0);
        check("reset cpu_reset_o", 32'(cpu_reset_o), 32'd1);
        check("reset done_o", 32'(done_o), 32'd0);
        check("reset error_o", 32'(error_o), 32'd0);
        rst = 1'b0;
        idle(1);

        // Good two-word frame, back-to-back; trailing bytes must be ignored
        tx_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hF9, 8'hB9};
        send_q(0);
        check("t1 release cpu_reset_o", 32'(cpu_reset_o), 32'd0);
        check("t1 release done_o", 32'(done_o), 32'd1);
        tx_q = '{8'h55, 8'hAA, 8'h01};
        send_q(0);
        idle(2);
        check("t1 write count", 32'(obs_log.size()), 32'd2);
        check("t1 write0", 32'(log_at(0)), 32'({9'h000, 16'h1234}));
        check("t1 write1", 32'(log_at(1)), 32'({9'h002, 16'hABCD}));

        // Same frame, bad checksum
        do_reset();
        tx_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h00};
        send_q(0);
        idle(2);
        check("t2 write count", 32'(obs_log.size()), 32'd2);
        check("t2 error_o", 32'(error_o), 32'd1);
        check("t2 cpu_reset_o", 32'(cpu_reset_o), 32'd1);
        check("t2 rx_ready_o", 32'(bus.rx_ready_o), 32'd0);

        // COUNT one past the limit
        do_reset();
        tx_q = '{8'h01, 8'h01};
        send_q(0);
        check("t3 error after count", 32'(error_o), 32'd1);
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_q(0);
        idle(2);
        check("t3 write count", 32'(obs_log.size()), 32'd0);

        // Empty image
        do_reset();
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_q(0);
        check("t4 done_o", 32'(done_o), 32'd1);
        idle(2);
        check("t4 write count", 32'(obs_log.size()), 32'd0);

        // Full 256-word image with random valid gaps
        do_reset();
        x = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            img[i] = 16'($urandom);
            x ^= img[i];
        end
        push_word(16'd256);
        for (int i = 0; i < 256; i++) push_word(img[i]);
        push_word(x);
        send_q(3);
        idle(2);
        check("t5 write count", 32'(obs_log.size()), 32'd256);
        check("t5 last addr", 32'(log_at(255) >> 16), 32'h1FE);
        for (int i = 0; i < 256; i++) check("t5 mem word", 32'(tb_mem[i]), 32'(img[i]));
        check("t5 done_o", 32'(done_o), 32'd1);

        // Reset in the middle of a frame, then a full frame
        do_reset();
        tx_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD};
        send_q(0);
        do_reset();
        tx_q = '{8'h01, 8'h00, 8'h5A, 8'hA5, 8'h5A, 8'hA5};
        send_q(1);
        idle(2);
        check("t6 write count", 32'(obs_log.size()), 32'd1);
        check("t6 first write", 32'(log_at(0)), 32'({9'h000, 16'hA55A}));
        check("t6 done_o", 32'(done_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
